// File: rtl/csr_unit_pkg.sv
// Shared types and constants for the CSR file: CSR numbers, exception codes
// and the commit-stage write bundle that the forwarding path also carries.
package csr_unit_pkg;

  typedef logic [13:0] csr_addr_t;

  typedef struct packed {
    logic      en;
    csr_addr_t addr;
    logic [31:0] data;
  } csr_write_t;

  localparam csr_addr_t CSR_CRMD   = 14'h000;
  localparam csr_addr_t CSR_PRMD   = 14'h001;
  localparam csr_addr_t CSR_ECFG   = 14'h004;
  localparam csr_addr_t CSR_ESTAT  = 14'h005;
  localparam csr_addr_t CSR_ERA    = 14'h006;
  localparam csr_addr_t CSR_BADV   = 14'h007;
  localparam csr_addr_t CSR_EENTRY = 14'h00C;
  localparam csr_addr_t CSR_SAVE0  = 14'h030;
  localparam csr_addr_t CSR_SAVE1  = 14'h031;
  localparam csr_addr_t CSR_SAVE2  = 14'h032;
  localparam csr_addr_t CSR_SAVE3  = 14'h033;
  localparam csr_addr_t CSR_TID    = 14'h040;
  localparam csr_addr_t CSR_TCFG   = 14'h041;
  localparam csr_addr_t CSR_TVAL   = 14'h042;
  localparam csr_addr_t CSR_TICLR  = 14'h044;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  // Address-related exceptions are the only ones that record a bad address.
  function automatic logic ecode_sets_badv(input logic [5:0] code);
    return (code == ECODE_PIL) || (code == ECODE_PIS) || (code == ECODE_PIF) ||
           (code == ECODE_PME) || (code == ECODE_PPI) || (code == ECODE_ADE) ||
           (code == ECODE_ALE) || (code == ECODE_TLBR);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: TCFG, the TVAL countdown and its enable, producing a
// one-cycle expiry pulse for the interrupt-pending logic.
module csr_timer
  import csr_unit_pkg::*;
#(
  parameter int TIMER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        timer_fire
);

  logic [TIMER_WIDTH-1:0] tval_q;
  logic [TIMER_WIDTH-1:0] reload_val;
  logic [TIMER_WIDTH-1:0] write_val;
  logic [31:0]            tcfg_q;
  logic                   timer_en;

  assign reload_val = {tcfg_q[TIMER_WIDTH-1:2], 2'b00};
  assign write_val  = {tcfg_wdata[TIMER_WIDTH-1:2], 2'b00};

  // A TCFG write reprograms the timer outright, so it also suppresses expiry.
  assign timer_fire = timer_en && (tval_q == '0) && !tcfg_we;

  assign tcfg = tcfg_q;
  assign tval = 32'(tval_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      tcfg_q   <= 32'h0;
      tval_q   <= '0;
      timer_en <= 1'b0;
    end else if (tcfg_we) begin
      tcfg_q   <= tcfg_wdata;
      tval_q   <= write_val;
      timer_en <= tcfg_wdata[0];
    end else if (timer_en) begin
      if (tval_q != '0)
        tval_q <= tval_q - 1'b1;
      else if (tcfg_q[1])
        tval_q <= reload_val;
      else
        timer_en <= 1'b0;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Architectural CSR file: exception entry/return bookkeeping, interrupt
// pending state and the CSR views consumed by the exception control block.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter int          TIMER_WIDTH = 32,
  parameter logic [31:0] TID_RESET   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_read_en,
  input  logic [13:0] csr_read_addr,
  output logic [31:0] csr_read_data,
  input  logic        csr_write_en,
  input  logic [13:0] csr_write_addr,
  input  logic [31:0] csr_write_data,
  input  logic        is_exception,
  input  logic [5:0]  ecode,
  input  logic [8:0]  esubcode,
  input  logic [31:0] exception_pc,
  input  logic [31:0] exception_addr,
  input  logic        is_ertn,
  input  logic [7:0]  hw_int,
  output logic [31:0] ERA_PC,
  output logic [31:0] EENTRY_VA,
  output logic [11:0] ECFG_LIE,
  output logic [11:0] ESTAT_IS,
  output logic [31:0] crmd
);

  csr_write_t wr;

  logic [8:0]  crmd_q;
  logic [2:0]  prmd_q;
  logic [11:0] ecfg_lie_q;
  logic [1:0]  estat_sw;
  logic [7:0]  estat_hw;
  logic        estat_ti;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esub;
  logic [31:0] era_q;
  logic [31:0] badv_q;
  logic [25:0] eentry_q;
  logic [31:0] save_q [4];
  logic [31:0] tid_q;
  logic [31:0] tcfg;
  logic [31:0] tval;
  logic        timer_fire;
  logic        ticlr_clear;
  logic [31:0] estat_word;

  assign wr          = '{en: csr_write_en, addr: csr_write_addr, data: csr_write_data};
  assign ticlr_clear = wr.en && (wr.addr == CSR_TICLR) && wr.data[0];

  csr_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .tcfg_we    (wr.en && (wr.addr == CSR_TCFG)),
    .tcfg_wdata (wr.data),
    .tcfg       (tcfg),
    .tval       (tval),
    .timer_fire (timer_fire)
  );

  // The older CSR write lands first; exception/ertn assignments come later
  // in the block so they override only the fields they own.
  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_q      <= 9'h008;
      prmd_q      <= 3'h0;
      ecfg_lie_q  <= 12'h0;
      estat_sw    <= 2'h0;
      estat_hw    <= 8'h0;
      estat_ti    <= 1'b0;
      estat_ecode <= 6'h0;
      estat_esub  <= 9'h0;
      era_q       <= 32'h0;
      badv_q      <= 32'h0;
      eentry_q    <= 26'h0;
      for (int i = 0; i < 4; i++) save_q[i] <= 32'h0;
      tid_q       <= TID_RESET;
    end else begin
      if (wr.en) begin
        case (wr.addr)
          CSR_CRMD:   crmd_q     <= wr.data[8:0];
          CSR_PRMD:   prmd_q     <= wr.data[2:0];
          CSR_ECFG:   ecfg_lie_q <= {wr.data[12:11], wr.data[9:0]};
          CSR_ESTAT:  estat_sw   <= wr.data[1:0];
          CSR_ERA:    era_q      <= wr.data;
          CSR_BADV:   badv_q     <= wr.data;
          CSR_EENTRY: eentry_q   <= wr.data[31:6];
          CSR_SAVE0:  save_q[0]  <= wr.data;
          CSR_SAVE1:  save_q[1]  <= wr.data;
          CSR_SAVE2:  save_q[2]  <= wr.data;
          CSR_SAVE3:  save_q[3]  <= wr.data;
          CSR_TID:    tid_q      <= wr.data;
          default: ;
        endcase
      end

      estat_hw <= hw_int;
      if (timer_fire)
        estat_ti <= 1'b1;
      else if (ticlr_clear)
        estat_ti <= 1'b0;

      if (is_exception) begin
        prmd_q      <= crmd_q[2:0];
        crmd_q[2:0] <= 3'b000;
        era_q       <= exception_pc;
        estat_ecode <= ecode;
        estat_esub  <= esubcode;
        if (ecode_sets_badv(ecode))
          badv_q <= exception_addr;
        if (ecode == ECODE_TLBR) begin
          crmd_q[3] <= 1'b1;
          crmd_q[4] <= 1'b0;
        end
      end else if (is_ertn) begin
        crmd_q[2:0] <= prmd_q;
        if (estat_ecode == ECODE_TLBR) begin
          crmd_q[3] <= 1'b0;
          crmd_q[4] <= 1'b1;
        end
      end
    end
  end

  // IS[12] (IPI) is tied low and bit 10 is a hole in the architecture.
  assign estat_word = {1'b0, estat_esub, estat_ecode, 3'b000,
                       1'b0, estat_ti, 1'b0, estat_hw, estat_sw};

  always_comb begin
    csr_read_data = 32'h0;
    if (csr_read_en) begin
      case (csr_read_addr)
        CSR_CRMD:   csr_read_data = {23'h0, crmd_q};
        CSR_PRMD:   csr_read_data = {29'h0, prmd_q};
        CSR_ECFG:   csr_read_data = {19'h0, ecfg_lie_q[11:10], 1'b0, ecfg_lie_q[9:0]};
        CSR_ESTAT:  csr_read_data = estat_word;
        CSR_ERA:    csr_read_data = era_q;
        CSR_BADV:   csr_read_data = badv_q;
        CSR_EENTRY: csr_read_data = {eentry_q, 6'h0};
        CSR_SAVE0:  csr_read_data = save_q[0];
        CSR_SAVE1:  csr_read_data = save_q[1];
        CSR_SAVE2:  csr_read_data = save_q[2];
        CSR_SAVE3:  csr_read_data = save_q[3];
        CSR_TID:    csr_read_data = tid_q;
        CSR_TCFG:   csr_read_data = tcfg;
        CSR_TVAL:   csr_read_data = tval;
        default:    csr_read_data = 32'h0;
      endcase
    end
  end

  assign ERA_PC    = era_q;
  assign EENTRY_VA = {eentry_q, 6'h0};
  assign ECFG_LIE  = ecfg_lie_q;
  assign ESTAT_IS  = {1'b0, estat_ti, estat_hw, estat_sw};
  assign crmd      = {23'h0, crmd_q};

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios with literal expected
// values, then randomized traffic checked against a word-level register model.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_read_en;
  logic [13:0] csr_read_addr;
  logic [31:0] csr_read_data;
  logic        csr_write_en;
  logic [13:0] csr_write_addr;
  logic [31:0] csr_write_data;
  logic        is_exception;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] exception_pc;
  logic [31:0] exception_addr;
  logic        is_ertn;
  logic [7:0]  hw_int;
  logic [31:0] ERA_PC;
  logic [31:0] EENTRY_VA;
  logic [11:0] ECFG_LIE;
  logic [11:0] ESTAT_IS;
  logic [31:0] crmd;

  int errors = 0;
  int checks = 0;

  // Reference model: each CSR as a full architectural 32-bit word.
  logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry;
  logic [31:0] m_save [4];
  logic [31:0] m_tid, m_tcfg, m_tval;
  logic        m_ten;

  csr_unit dut (
    .clk            (clk),
    .rst            (rst),
    .csr_read_en    (csr_read_en),
    .csr_read_addr  (csr_read_addr),
    .csr_read_data  (csr_read_data),
    .csr_write_en   (csr_write_en),
    .csr_write_addr (csr_write_addr),
    .csr_write_data (csr_write_data),
    .is_exception   (is_exception),
    .ecode          (ecode),
    .esubcode       (esubcode),
    .exception_pc   (exception_pc),
    .exception_addr (exception_addr),
    .is_ertn        (is_ertn),
    .hw_int         (hw_int),
    .ERA_PC         (ERA_PC),
    .EENTRY_VA      (EENTRY_VA),
    .ECFG_LIE       (ECFG_LIE),
    .ESTAT_IS       (ESTAT_IS),
    .crmd           (crmd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] mask);
    return (old & ~mask) | (wd & mask);
  endfunction

  function automatic logic [31:0] model_read(input logic [13:0] a);
    case (a)
      14'h000: return m_crmd;
      14'h001: return m_prmd;
      14'h004: return m_ecfg;
      14'h005: return m_estat;
      14'h006: return m_era;
      14'h007: return m_badv;
      14'h00C: return m_eentry;
      14'h030: return m_save[0];
      14'h031: return m_save[1];
      14'h032: return m_save[2];
      14'h033: return m_save[3];
      14'h040: return m_tid;
      14'h041: return m_tcfg;
      14'h042: return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] o_crmd, o_prmd, o_estat, o_tcfg, o_tval;
    logic        o_ten, fire, tcfg_wr;
    o_crmd = m_crmd; o_prmd = m_prmd; o_estat = m_estat;
    o_tcfg = m_tcfg; o_tval = m_tval; o_ten = m_ten;
    if (rst) begin
      m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_badv = 0;
      m_eentry = 0; m_tid = 32'h0; m_tcfg = 0; m_tval = 0; m_ten = 1'b0;
      for (int i = 0; i < 4; i++) m_save[i] = 0;
      return;
    end
    tcfg_wr = csr_write_en && csr_write_addr == 14'h041;
    if (csr_write_en) begin
      case (csr_write_addr)
        14'h000: m_crmd   = merge(m_crmd,   csr_write_data, 32'h0000_01FF);
        14'h001: m_prmd   = merge(m_prmd,   csr_write_data, 32'h0000_0007);
        14'h004: m_ecfg   = merge(m_ecfg,   csr_write_data, 32'h0000_1BFF);
        14'h005: m_estat  = merge(m_estat,  csr_write_data, 32'h0000_0003);
        14'h006: m_era    = csr_write_data;
        14'h007: m_badv   = csr_write_data;
        14'h00C: m_eentry = merge(m_eentry, csr_write_data, 32'hFFFF_FFC0);
        14'h030: m_save[0] = csr_write_data;
        14'h031: m_save[1] = csr_write_data;
        14'h032: m_save[2] = csr_write_data;
        14'h033: m_save[3] = csr_write_data;
        14'h040: m_tid    = csr_write_data;
        default: ;
      endcase
    end
    m_estat = merge(m_estat, {22'h0, hw_int, 2'b00}, 32'h0000_03FC);
    fire = o_ten && o_tval == 0 && !tcfg_wr;
    if (tcfg_wr) begin
      m_tcfg = csr_write_data;
      m_tval = csr_write_data & 32'hFFFF_FFFC;
      m_ten  = csr_write_data[0];
    end else if (o_ten) begin
      if (o_tval != 0) m_tval = o_tval - 1;
      else if (o_tcfg[1]) m_tval = o_tcfg & 32'hFFFF_FFFC;
      else m_ten = 1'b0;
    end
    if (fire) m_estat[11] = 1'b1;
    else if (csr_write_en && csr_write_addr == 14'h044 && csr_write_data[0]) m_estat[11] = 1'b0;
    if (is_exception) begin
      m_prmd[2:0] = o_crmd[2:0];
      m_crmd[2:0] = 3'b000;
      m_era = exception_pc;
      m_estat[21:16] = ecode;
      m_estat[30:22] = esubcode;
      if (ecode inside {6'h1, 6'h2, 6'h3, 6'h4, 6'h7, 6'h8, 6'h9, 6'h3F}) m_badv = exception_addr;
      if (ecode == 6'h3F) begin m_crmd[3] = 1'b1; m_crmd[4] = 1'b0; end
    end else if (is_ertn) begin
      m_crmd[2:0] = o_prmd[2:0];
      if (o_estat[21:16] == 6'h3F) begin m_crmd[3] = 1'b0; m_crmd[4] = 1'b1; end
    end
  endtask

  // One clock with the current inputs, then drop the one-shot strobes.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    csr_write_en = 1'b0;
    is_exception = 1'b0;
    is_ertn      = 1'b0;
  endtask

  task automatic write_csr(input logic [13:0] a, input logic [31:0] d);
    csr_write_en = 1'b1; csr_write_addr = a; csr_write_data = d;
  endtask

  task automatic read_csr(input logic [13:0] a, output logic [31:0] d);
    csr_read_en = 1'b1; csr_read_addr = a;
    #1;
    d = csr_read_data;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (crmd !== 32'h8) begin errors++; $display("[TB] FAIL reset_crmd got=%h exp=%h", crmd, 32'h8); end
    checks++; if (EENTRY_VA !== 32'h0) begin errors++; $display("[TB] FAIL reset_eentry got=%h exp=0", EENTRY_VA); end
    read_csr(14'h000, d);
    checks++; if (d !== 32'h8) begin errors++; $display("[TB] FAIL reset_read_crmd got=%h exp=8", d); end
    read_csr(14'h005, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_read_estat got=%h exp=0", d); end
    read_csr(14'h042, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_read_tval got=%h exp=0", d); end
  endtask

  task automatic test_exception_ertn();
    logic [31:0] d;
    write_csr(14'h000, 32'h7);
    tick();
    is_exception = 1'b1; ecode = 6'h9; esubcode = 9'h0;
    exception_pc = 32'h1c00_0100; exception_addr = 32'h1c00_08f3;
    tick();
    checks++; if (crmd[2:0] !== 3'h0) begin errors++; $display("[TB] FAIL exc_crmd_plvie got=%h exp=0", crmd[2:0]); end
    checks++; if (ERA_PC !== 32'h1c00_0100) begin errors++; $display("[TB] FAIL exc_era got=%h exp=1c000100", ERA_PC); end
    read_csr(14'h001, d);
    checks++; if (d[2:0] !== 3'h7) begin errors++; $display("[TB] FAIL exc_prmd got=%h exp=7", d[2:0]); end
    read_csr(14'h007, d);
    checks++; if (d !== 32'h1c00_08f3) begin errors++; $display("[TB] FAIL exc_badv got=%h exp=1c0008f3", d); end
    read_csr(14'h005, d);
    checks++; if (d[21:16] !== 6'h9) begin errors++; $display("[TB] FAIL exc_ecode got=%h exp=9", d[21:16]); end
    is_ertn = 1'b1;
    tick();
    checks++; if (crmd[2:0] !== 3'h7) begin errors++; $display("[TB] FAIL ertn_crmd got=%h exp=7", crmd[2:0]); end
  endtask

  task automatic test_sys_badv_keep();
    logic [31:0] d;
    write_csr(14'h007, 32'h55);
    tick();
    write_csr(14'h030, 32'hdead);
    is_exception = 1'b1; ecode = 6'hB; esubcode = 9'h0;
    exception_pc = 32'h1c00_0200; exception_addr = 32'h1234_5678;
    tick();
    read_csr(14'h007, d);
    checks++; if (d !== 32'h55) begin errors++; $display("[TB] FAIL sys_badv got=%h exp=55", d); end
    read_csr(14'h030, d);
    checks++; if (d !== 32'hdead) begin errors++; $display("[TB] FAIL sys_save0 got=%h exp=dead", d); end
  endtask

  task automatic test_timer_periodic();
    logic [31:0] d;
    write_csr(14'h041, 32'h13);
    tick();
    read_csr(14'h042, d);
    checks++; if (d !== 32'd16) begin errors++; $display("[TB] FAIL per_tval_load got=%0d exp=16", d); end
    for (int i = 0; i < 16; i++) tick();
    read_csr(14'h042, d);
    checks++; if (d !== 32'd0 || ESTAT_IS[10] !== 1'b0) begin errors++; $display("[TB] FAIL per_at_zero tval=%0d is11=%b exp 0/0", d, ESTAT_IS[10]); end
    tick();
    read_csr(14'h042, d);
    checks++; if (ESTAT_IS[10] !== 1'b1) begin errors++; $display("[TB] FAIL per_fire got=%b exp=1", ESTAT_IS[10]); end
    checks++; if (d !== 32'd16) begin errors++; $display("[TB] FAIL per_reload got=%0d exp=16", d); end
    for (int i = 0; i < 16; i++) tick();
    write_csr(14'h044, 32'h1);
    tick();
    checks++; if (ESTAT_IS[10] !== 1'b1) begin errors++; $display("[TB] FAIL per_ticlr_vs_fire got=%b exp=1", ESTAT_IS[10]); end
  endtask

  task automatic test_timer_oneshot();
    logic [31:0] d;
    write_csr(14'h044, 32'h1);
    tick();
    checks++; if (ESTAT_IS[10] !== 1'b0) begin errors++; $display("[TB] FAIL ticlr_clear got=%b exp=0", ESTAT_IS[10]); end
    write_csr(14'h041, 32'h9);
    tick();
    for (int i = 0; i < 8; i++) tick();
    checks++; if (ESTAT_IS[10] !== 1'b0) begin errors++; $display("[TB] FAIL one_early got=%b exp=0", ESTAT_IS[10]); end
    tick();
    checks++; if (ESTAT_IS[10] !== 1'b1) begin errors++; $display("[TB] FAIL one_fire got=%b exp=1", ESTAT_IS[10]); end
    write_csr(14'h044, 32'h1);
    tick();
    for (int i = 0; i < 12; i++) tick();
    read_csr(14'h042, d);
    checks++; if (ESTAT_IS[10] !== 1'b0 || d !== 32'h0) begin errors++; $display("[TB] FAIL one_no_refire is11=%b tval=%0d exp 0/0", ESTAT_IS[10], d); end
  endtask

  task automatic test_interrupts();
    hw_int = 8'h01;
    write_csr(14'h004, 32'h4);
    tick();
    checks++; if (ESTAT_IS[2] !== 1'b1) begin errors++; $display("[TB] FAIL hw_is2 got=%b exp=1", ESTAT_IS[2]); end
    checks++; if (ECFG_LIE !== 12'h004) begin errors++; $display("[TB] FAIL ecfg_lie got=%h exp=004", ECFG_LIE); end
    write_csr(14'h005, 32'hFFFF);
    tick();
    checks++; if (ESTAT_IS !== 12'h007) begin errors++; $display("[TB] FAIL estat_write got=%h exp=007", ESTAT_IS); end
    hw_int = 8'h00;
  endtask

  task automatic test_random();
    logic [13:0] addrs [18] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                                14'h00C, 14'h030, 14'h031, 14'h032, 14'h033, 14'h040,
                                14'h041, 14'h042, 14'h044, 14'h002, 14'h043, 14'h3FFF};
    logic [5:0]  codes [11] = '{6'h0, 6'h1, 6'h2, 6'h3, 6'h4, 6'h7, 6'h8, 6'h9,
                                6'hB, 6'hC, 6'h3F};
    logic [31:0] d, e;
    logic [13:0] ra;
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(0, 99) == 0);
      csr_write_en   = ($urandom_range(0, 1) == 1);
      csr_write_addr = addrs[$urandom_range(0, 17)];
      csr_write_data = $urandom;
      if (csr_write_addr == 14'h041) csr_write_data = csr_write_data & 32'h3F;
      is_exception   = ($urandom_range(0, 7) == 0);
      is_ertn        = ($urandom_range(0, 7) == 0);
      ecode          = codes[$urandom_range(0, 10)];
      esubcode       = 9'($urandom);
      exception_pc   = $urandom;
      exception_addr = $urandom;
      hw_int         = 8'($urandom);
      tick();
      rst = 1'b0;
      checks++; if (crmd !== m_crmd) begin errors++; $display("[TB] FAIL rnd_crmd cyc=%0d got=%h exp=%h", n, crmd, m_crmd); end
      checks++; if (ERA_PC !== m_era) begin errors++; $display("[TB] FAIL rnd_era cyc=%0d got=%h exp=%h", n, ERA_PC, m_era); end
      checks++; if (EENTRY_VA !== m_eentry) begin errors++; $display("[TB] FAIL rnd_eentry cyc=%0d got=%h exp=%h", n, EENTRY_VA, m_eentry); end
      checks++; if (ECFG_LIE !== {m_ecfg[12:11], m_ecfg[9:0]}) begin errors++; $display("[TB] FAIL rnd_lie cyc=%0d got=%h exp=%h", n, ECFG_LIE, {m_ecfg[12:11], m_ecfg[9:0]}); end
      checks++; if (ESTAT_IS !== {m_estat[12:11], m_estat[9:0]}) begin errors++; $display("[TB] FAIL rnd_is cyc=%0d got=%h exp=%h", n, ESTAT_IS, {m_estat[12:11], m_estat[9:0]}); end
      ra = addrs[$urandom_range(0, 17)];
      read_csr(ra, d);
      e = model_read(ra);
      checks++; if (d !== e) begin errors++; $display("[TB] FAIL rnd_read cyc=%0d addr=%h got=%h exp=%h", n, ra, d, e); end
    end
  endtask

  initial begin
    rst = 1'b0; csr_read_en = 1'b0; csr_read_addr = '0;
    csr_write_en = 1'b0; csr_write_addr = '0; csr_write_data = '0;
    is_exception = 1'b0; ecode = '0; esubcode = '0;
    exception_pc = '0; exception_addr = '0; is_ertn = 1'b0; hw_int = '0;
    #2;
    test_reset();
    test_exception_ertn();
    test_sys_badv_keep();
    test_timer_periodic();
    test_timer_oneshot();
    test_interrupts();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
